// File: rtl/uart_receiver_if.sv
// Byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ack;

  modport master (output data_out, output data_valid, input data_ack);
  modport slave  (input data_out, input data_valid, output data_ack);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling, valid/ack byte handshake, framing and overrun flags.
// Optional even-parity checking is compiled in with the UART_RX_PARITY_EN macro.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  uart_receiver_if.master bus,
  output logic            busy,
  output logic            frame_err,
  output logic            overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 deliver;
  logic                 rx_meta;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // A good stop bit raises deliver; the byte is published on the following edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shift_reg      <= '0;
      deliver        <= 1'b0;
      busy           <= 1'b0;
      frame_err      <= 1'b0;
      overrun        <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad        <= 1'b0;
      parity_err     <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      deliver   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            shift_reg[bit_idx] <= rx_s;
            cnt                <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            par_bad    <= (rx_s != ^shift_reg);
            parity_err <= (rx_s != ^shift_reg);
            state      <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              deliver <= !par_bad;
`else
              deliver <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A byte completing on the ack edge wins over the ack.
      if (deliver) begin
        bus.data_out   <= shift_reg;
        bus.data_valid <= 1'b1;
        if (bus.data_valid && !bus.data_ack) overrun <= 1'b1;
      end else if (bus.data_valid && bus.data_ack) begin
        bus.data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table-driven frames plus hand-written corner sequences.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_receiver;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         stop_periods;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  logic clk;
  logic rst;
  logic rx;
  logic busy;
  logic frame_err;
  logic overrun;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  uart_receiver_if #(.DATA_BITS(8)) bus ();

  uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .bus       (bus),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int ferr_count = 0;
  int perr_count = 0;
  logic prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.data_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = bus.data_valid;
    if (frame_err) ferr_count++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_count++;
`endif
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame cycle by cycle; must be called #1 after a rising edge.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int stop_periods,
                            input logic par_flip, input int max_cycles);
    logic bits[$];
    int total;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef UART_RX_PARITY_EN
    bits.push_back((^data) ^ par_flip);
`else
    if (par_flip) bits.push_back(1'b1);
`endif
    for (int i = 0; i < stop_periods; i++) bits.push_back(stop_bit);
    total = bits.size() * CPB;
    if (max_cycles > 0 && max_cycles < total) total = max_cycles;
    start_cyc = cyc + 1;
    for (int c = 0; c < total; c++) begin
      rx = bits[c / CPB];
      @(posedge clk);
      #1;
    end
    if (max_cycles == 0) rx = 1'b1;
  endtask

  task automatic ack_byte(input string name);
    bus.data_ack = 1'b1;
    step(1);
    bus.data_ack = 1'b0;
    checkOutput(name, bus.data_valid, 1'b0);
  endtask

  task automatic applyStimulus(input vec_t v, output int ferr_delta);
    int f0;
    f0 = ferr_count;
    send_frame(v.data, v.stop_bit, v.stop_periods, 1'b0, 0);
    step(24);
    ferr_delta = ferr_count - f0;
  endtask

  vec_t vecs[6];
  logic [7:0] first_byte;
  logic got_first;
  int fdelta;
  int f0;
  int p0;
  logic seen_idle;

  initial begin
    vecs[0] = '{8'h81, 1'b1, 1, 1'b1, 8'h81, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 1'b1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 1'b1, 8'hFF, 0};
    vecs[3] = '{8'h55, 1'b1, 1, 1'b1, 8'h55, 0};
    vecs[4] = '{8'h8B, 1'b0, 2, 1'b0, 8'h00, 1};
    vecs[5] = '{8'hAA, 1'b1, 1, 1'b1, 8'hAA, 0};

    rst = 1'b0;
    rx = 1'b1;
    bus.data_ack = 1'b0;
    step(3);
    checkOutput("reset data_valid", bus.data_valid, 1'b0);
    checkOutput("reset data_out", bus.data_out, 8'h00);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset frame_err", frame_err, 1'b0);
    checkOutput("reset overrun", overrun, 1'b0);
    rst = 1'b1;
    step(5);

    // Latency from the start edge for 0x81.
    rise_cyc = -1;
    send_frame(8'h81, 1'b1, 1, 1'b0, 0);
    step(4);
    checkOutput("latency 0x81", rise_cyc - start_cyc, LAT);
    checkOutput("latency data_out", bus.data_out, 8'h81);
    ack_byte("ack clears valid 0x81");

    bus.data_ack = 1'b1;
    step(1);
    bus.data_ack = 1'b0;
    step(2);
    checkOutput("idle ack ignored", bus.data_valid, 1'b0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], fdelta);
      checkOutput($sformatf("vec%0d valid", i), bus.data_valid, vecs[i].exp_valid);
      checkOutput($sformatf("vec%0d frame_err pulses", i), fdelta, vecs[i].exp_ferr);
      checkOutput($sformatf("vec%0d overrun", i), overrun, 1'b0);
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].exp_data);
        ack_byte($sformatf("vec%0d ack", i));
      end
    end

    // Short low glitch on an idle line.
    f0 = ferr_count;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    checkOutput("glitch busy seen", busy, 1'b1);
    seen_idle = 1'b0;
    for (int i = 0; i < 10 && !seen_idle; i++) begin
      step(1);
      if (!busy) seen_idle = 1'b1;
    end
    checkOutput("glitch busy returns", seen_idle, 1'b1);
    step(20);
    checkOutput("glitch no valid", bus.data_valid, 1'b0);
    checkOutput("glitch no frame_err", ferr_count - f0, 0);

    // Back-to-back with the first byte acked.
    got_first = 1'b0;
    first_byte = 8'h00;
    fork
      begin
        send_frame(8'h8B, 1'b1, 1, 1'b0, 0);
        send_frame(8'hAA, 1'b1, 1, 1'b0, 0);
      end
      begin
        for (int i = 0; i < 400 && !got_first; i++) begin
          step(1);
          if (bus.data_valid) got_first = 1'b1;
        end
        first_byte = bus.data_out;
        bus.data_ack = 1'b1;
        step(1);
        bus.data_ack = 1'b0;
      end
    join
    step(4);
    checkOutput("b2b ack first valid seen", got_first, 1'b1);
    checkOutput("b2b ack first byte", first_byte, 8'h8B);
    checkOutput("b2b ack second valid", bus.data_valid, 1'b1);
    checkOutput("b2b ack second byte", bus.data_out, 8'hAA);
    checkOutput("b2b ack overrun", overrun, 1'b0);
    ack_byte("b2b ack clear");

    // Back-to-back without ack.
    send_frame(8'h8B, 1'b1, 1, 1'b0, 0);
    send_frame(8'hAA, 1'b1, 1, 1'b0, 0);
    step(4);
    checkOutput("overrun valid", bus.data_valid, 1'b1);
    checkOutput("overrun data_out", bus.data_out, 8'hAA);
    checkOutput("overrun flag", overrun, 1'b1);

    // Reset in the middle of data bit 4.
    send_frame(8'h55, 1'b1, 1, 1'b0, 5 * CPB + CPB / 2);
    checkOutput("mid-frame busy", busy, 1'b1);
    rst = 1'b0;
    rx = 1'b1;
    step(1);
    checkOutput("midreset data_valid", bus.data_valid, 1'b0);
    checkOutput("midreset data_out", bus.data_out, 8'h00);
    checkOutput("midreset busy", busy, 1'b0);
    checkOutput("midreset overrun", overrun, 1'b0);
    checkOutput("midreset frame_err", frame_err, 1'b0);
    rst = 1'b1;
    step(5);
    send_frame(8'h55, 1'b1, 1, 1'b0, 0);
    step(4);
    checkOutput("post-reset valid", bus.data_valid, 1'b1);
    checkOutput("post-reset data_out", bus.data_out, 8'h55);
    ack_byte("post-reset ack");

`ifdef UART_RX_PARITY_EN
    p0 = perr_count;
    send_frame(8'h81, 1'b1, 1, 1'b0, 0);
    step(4);
    checkOutput("parity ok valid", bus.data_valid, 1'b1);
    checkOutput("parity ok data", bus.data_out, 8'h81);
    checkOutput("parity ok no err", perr_count - p0, 0);
    ack_byte("parity ok ack");
    p0 = perr_count;
    send_frame(8'h81, 1'b1, 1, 1'b1, 0);
    step(4);
    checkOutput("parity bad pulse", perr_count - p0, 1);
    checkOutput("parity bad no valid", bus.data_valid, 1'b0);
`else
    p0 = perr_count;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
